// File: rtl/bsg_sync_sync_pkg.sv
// Shared constants and helpers for the bsg_sync_sync family of synchronizers.
// Used by bsg_sync_sync_filtered and bsg_sync_sync_filtered_chan.
package bsg_sync_sync_pkg;

  // Fewest flops per bit that still give a usable settling window.
  localparam int bsg_sync_sync_min_stages_gp = 2;

  // Width of the stability counter, which must hold 0..stable_cycles inclusive.
  // Clamped to at least one bit so a degenerate parameter still elaborates
  // far enough to reach the legality checks.
  function automatic int bsg_sync_sync_cnt_width(input int stable_cycles);
    if (stable_cycles < 1) begin
      return 1;
    end
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/bsg_sync_sync_filtered_chan.sv
// One channel of bsg_sync_sync_filtered: a stages_p-deep synchronizer chain per
// bit, followed by either a direct hold register or a stability filter that
// only passes a word once it has been unchanged for stable_cycles_p cycles.
// Compile-time option: BSG_SYNC_SYNC_FILTER_EN enables the stability filter.
module bsg_sync_sync_filtered_chan
  import bsg_sync_sync_pkg::*;
#(
  parameter int width_p         = 8,
  parameter int stages_p        = 2,
  parameter int stable_cycles_p = 4
) (
  input  logic               oclk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] iclk_data_i,
  output logic [width_p-1:0] oclk_data_o,
  output logic               oclk_changed_o
);

  // Parameter legality, reported while elaborating rather than at run time.
  if (stages_p < bsg_sync_sync_min_stages_gp) begin : g_bad_stages
    $error("bsg_sync_sync_filtered_chan: stages_p must be at least %0d",
           bsg_sync_sync_min_stages_gp);
  end
  if (stable_cycles_p < 1) begin : g_bad_stable
    $error("bsg_sync_sync_filtered_chan: stable_cycles_p must be at least 1");
  end

  // Synchronizer chain: element 0 is the capture flop, the top element is the
  // settled output. Nothing sits between stages so every flop gets a full
  // cycle to resolve metastability.
  (* ASYNC_REG = "TRUE" *)
  logic [stages_p-1:0][width_p-1:0] sync_r;
  logic [width_p-1:0]               last;

  logic [width_p-1:0] held_r;
  logic               changed_r;

  // Shift the asynchronous word through the chain, clearing it on reset.
  always_ff @(posedge oclk_i) begin
    if (reset_i) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[stages_p-2:0], iclk_data_i};
    end
  end

  assign last = sync_r[stages_p-1];

`ifdef BSG_SYNC_SYNC_FILTER_EN

  localparam int cnt_w_lp = bsg_sync_sync_cnt_width(stable_cycles_p);
  // Saturation point of the counter and the count at which the word qualifies
  // (the qualifying edge is the one that would carry cnt to its maximum).
  localparam logic [cnt_w_lp-1:0] cnt_max_lp  = cnt_w_lp'(stable_cycles_p);
  localparam logic [cnt_w_lp-1:0] cnt_fire_lp = cnt_w_lp'(stable_cycles_p - 1);

  logic [width_p-1:0]  prev_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                same_as_prev;
  logic                qualifies;

  // Full-width compare: any bit moving restarts the stability window, which is
  // what hides the incoherent intermediate codes of a multi-bit transition.
  assign same_as_prev = (last == prev_r);
  assign qualifies    = same_as_prev && (cnt_r == cnt_fire_lp) && (last != held_r);

  // Track how long the settled word has been steady, saturating at the limit.
  always_ff @(posedge oclk_i) begin
    if (reset_i) begin
      prev_r <= '0;
      cnt_r  <= '0;
    end else begin
      prev_r <= last;
      if (!same_as_prev) begin
        cnt_r <= '0;
      end else if (cnt_r != cnt_max_lp) begin
        cnt_r <= cnt_r + cnt_w_lp'(1);
      end
    end
  end

  // Commit a qualified word to the output and strobe for exactly one cycle.
  // A word that returns to the held value mid-count never qualifies, so it
  // produces neither an update nor a pulse.
  always_ff @(posedge oclk_i) begin
    if (reset_i) begin
      held_r    <= '0;
      changed_r <= 1'b0;
    end else if (qualifies) begin
      held_r    <= last;
      changed_r <= 1'b1;
    end else begin
      changed_r <= 1'b0;
    end
  end

`else

  // Unfiltered: follow the settled word every cycle and flag any difference.
  always_ff @(posedge oclk_i) begin
    if (reset_i) begin
      held_r    <= '0;
      changed_r <= 1'b0;
    end else begin
      held_r    <= last;
      changed_r <= (last != held_r);
    end
  end

`endif

  assign oclk_data_o    = held_r;
  assign oclk_changed_o = changed_r;

endmodule

// File: rtl/bsg_sync_sync_filtered.sv
// Multi-channel, multi-stage synchronizer into the oclk_i domain with a
// registered per-channel change pulse. Each channel is an independent
// bsg_sync_sync_filtered_chan; channel c occupies bits [c*width_p +: width_p].
// Compile-time option: BSG_SYNC_SYNC_FILTER_EN enables the per-channel
// stability filter (stable_cycles_p is ignored when it is not defined).
module bsg_sync_sync_filtered
  import bsg_sync_sync_pkg::*;
#(
  parameter int width_p         = 8,
  parameter int channels_p      = 2,
  parameter int stages_p        = 2,
  parameter int stable_cycles_p = 4
) (
  input  logic                          oclk_i,
  input  logic                          reset_i,
  input  logic [channels_p*width_p-1:0] iclk_data_i,
  output logic [channels_p*width_p-1:0] oclk_data_o,
  output logic [channels_p-1:0]         oclk_changed_o
);

  if (channels_p < 1) begin : g_bad_channels
    $error("bsg_sync_sync_filtered: channels_p must be at least 1");
  end
  if (width_p < 1) begin : g_bad_width
    $error("bsg_sync_sync_filtered: width_p must be at least 1");
  end

  // One fully independent synchronizer/filter per channel slice.
  for (genvar gi = 0; gi < channels_p; gi++) begin : g_chan
    bsg_sync_sync_filtered_chan #(
      .width_p        (width_p),
      .stages_p       (stages_p),
      .stable_cycles_p(stable_cycles_p)
    ) chan (
      .oclk_i        (oclk_i),
      .reset_i       (reset_i),
      .iclk_data_i   (iclk_data_i[gi*width_p +: width_p]),
      .oclk_data_o   (oclk_data_o[gi*width_p +: width_p]),
      .oclk_changed_o(oclk_changed_o[gi])
    );
  end

endmodule

// File: tb/tb_bsg_sync_sync_filtered.sv
// Scoreboard bench for bsg_sync_sync_filtered. Two instances share the input
// bus: stages_p=2 and stages_p=3 (one cycle more latency). Expected pulses
// are queued with their cycle when stimulus is driven; a negedge monitor
// pops and compares whenever a change pulse appears.
// Expectations follow BSG_SYNC_SYNC_FILTER_EN when it is defined.
module tb_bsg_sync_sync_filtered;

`ifdef BSG_SYNC_SYNC_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 2 + 4;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 2;
`endif

  typedef struct {
    int          cyc;
    logic [1:0]  chg;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] iclk_data;
  logic [15:0] data2, data3;
  logic [1:0]  chg2, chg3;

  int   cyc     = 0;
  int   t_drive = 0;
  int   tests   = 0;
  int   fails   = 0;
  bit   rst_q   = 1'b1;
  exp_t q0[$];
  exp_t q1[$];
  logic [15:0] last_data [2];

  always #5 clk = ~clk;

  bsg_sync_sync_filtered #(
    .width_p(8), .channels_p(2), .stages_p(2), .stable_cycles_p(4)
  ) dut2 (
    .oclk_i(clk), .reset_i(reset_i), .iclk_data_i(iclk_data),
    .oclk_data_o(data2), .oclk_changed_o(chg2)
  );

  bsg_sync_sync_filtered #(
    .width_p(8), .channels_p(2), .stages_p(3), .stable_cycles_p(4)
  ) dut3 (
    .oclk_i(clk), .reset_i(reset_i), .iclk_data_i(iclk_data),
    .oclk_data_o(data3), .oclk_changed_o(chg3)
  );

  // Cycle count and the reset value seen at each edge.
  always @(posedge clk) begin
    cyc   = cyc + 1;
    rst_q = reset_i;
  end

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic check_one(input int d, input logic [15:0] data, input logic [1:0] chg);
    exp_t e;
    if (rst_q) begin
      tests++;
      if (data !== 16'h0 || chg !== 2'b00) begin
        fails++;
        $display("FAIL reset_out dut%0d cyc=%0d got data=%h chg=%b need data=0000 chg=00",
                 d, cyc, data, chg);
      end
      last_data[d] = data;
      return;
    end
    while (qsize(d) > 0) begin
      e = qfront(d);
      if (e.cyc >= cyc) break;
      tests++;
      fails++;
      $display("FAIL missed_pulse dut%0d got none by cyc=%0d need chg=%b data=%h at cyc=%0d",
               d, cyc, e.chg, e.data, e.cyc);
      qpop(d);
    end
    if (chg !== 2'b00) begin
      tests++;
      if (qsize(d) == 0) begin
        fails++;
        $display("FAIL extra_pulse dut%0d cyc=%0d got chg=%b data=%h need no pulse",
                 d, cyc, chg, data);
      end else begin
        e = qfront(d);
        qpop(d);
        if (e.cyc != cyc || e.chg !== chg || e.data !== data) begin
          fails++;
          $display("FAIL pulse dut%0d got cyc=%0d chg=%b data=%h need cyc=%0d chg=%b data=%h",
                   d, cyc, chg, data, e.cyc, e.chg, e.data);
        end else begin
          $display("[TB] dut%0d pulse cyc=%0d chg=%b data=%h ok", d, cyc, chg, data);
        end
      end
    end else begin
      tests++;
      if (data !== last_data[d]) begin
        fails++;
        $display("FAIL silent_change dut%0d cyc=%0d got data=%h need %h (no pulse)",
                 d, cyc, data, last_data[d]);
      end
    end
    last_data[d] = data;
  endtask

  // Monitor: compare both instances away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check_one(0, data2, chg2);
      check_one(1, data3, chg3);
    end
  end

  task automatic drive_after(input int n, input logic [15:0] v);
    repeat (n) @(negedge clk);
    iclk_data = v;
    t_drive   = cyc;
    $display("[TB] drive cyc=%0d data=%h", cyc, v);
  endtask

  // Queue an expected pulse for the word just driven on both instances.
  task automatic expect_pulse(input logic [1:0] chg, input logic [15:0] data);
    exp_t e;
    e.chg  = chg;
    e.data = data;
    e.cyc  = t_drive + 1 + LAT;
    q0.push_back(e);
    e.cyc  = t_drive + 2 + LAT;
    q1.push_back(e);
  endtask

  initial begin
    last_data[0] = 16'h0;
    last_data[1] = 16'h0;
    reset_i   = 1'b1;
    iclk_data = 16'hFFFF;
    repeat (3) @(negedge clk);

    // Release with all-ones present: first update after full latency.
    reset_i = 1'b0;
    t_drive = cyc;
    expect_pulse(2'b11, 16'hFFFF);
    repeat (12) @(negedge clk);

    drive_after(1, 16'h0000); expect_pulse(2'b11, 16'h0000);
    repeat (12) @(negedge clk);

    // Channel 0 only.
    drive_after(1, 16'h00A5); expect_pulse(2'b01, 16'h00A5);
    repeat (12) @(negedge clk);

    // Channel 1 only.
    drive_after(1, 16'h3CA5); expect_pulse(2'b10, 16'h3CA5);
    repeat (12) @(negedge clk);

    // Channel 1 toggles every 2 cycles: filtered build never qualifies it.
    drive_after(1, 16'h00A5); if (!FILT) expect_pulse(2'b10, 16'h00A5);
    drive_after(2, 16'h3CA5); if (!FILT) expect_pulse(2'b10, 16'h3CA5);
    drive_after(2, 16'h00A5); if (!FILT) expect_pulse(2'b10, 16'h00A5);
    drive_after(2, 16'h3CA5); if (!FILT) expect_pulse(2'b10, 16'h3CA5);
    repeat (14) @(negedge clk);

    // Bounce-back on channel 0 from a held 11.
    drive_after(1, 16'h3C11); expect_pulse(2'b01, 16'h3C11);
    repeat (12) @(negedge clk);
    drive_after(1, 16'h3C22); if (!FILT) expect_pulse(2'b01, 16'h3C22);
    drive_after(2, 16'h3C11); if (!FILT) expect_pulse(2'b01, 16'h3C11);
    repeat (14) @(negedge clk);

    // Simultaneous change on both channels.
    drive_after(1, 16'h5A77); expect_pulse(2'b11, 16'h5A77);
    repeat (12) @(negedge clk);

    // Reset sampled at E4 of an update, then re-qualify after release.
    drive_after(1, 16'h1234);
    if (!FILT) expect_pulse(2'b11, 16'h1234);
    repeat (4) @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    t_drive = cyc;
    expect_pulse(2'b11, 16'h1234);
    repeat (20) @(negedge clk);

    while (q0.size() > 0) begin
      tests++; fails++;
      $display("FAIL leftover dut0 got none need chg=%b data=%h at cyc=%0d",
               q0[0].chg, q0[0].data, q0[0].cyc);
      void'(q0.pop_front());
    end
    while (q1.size() > 0) begin
      tests++; fails++;
      $display("FAIL leftover dut1 got none need chg=%b data=%h at cyc=%0d",
               q1[0].chg, q1[0].data, q1[0].cyc);
      void'(q1.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
